// File: rtl/dla_vram_arbiter.sv
// dla_vram_arbiter: shares one Avalon-MM VRAM port among NREQ requesters and routes read responses in order.
// Define DLA_ARB_RR_EN for round-robin arbitration; fixed priority (index 0 highest) otherwise.
module dla_vram_arbiter #(
  parameter int NREQ   = 3,
  parameter int AVN_AW = 19,
  parameter int AVN_DW = 16,
  parameter int OUTSTD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ*AVN_AW-1:0]   s_address,
  input  logic [NREQ-1:0]          s_read,
  input  logic [NREQ-1:0]          s_write,
  input  logic [NREQ*AVN_DW-1:0]   s_writedata,
  output logic [NREQ-1:0]          s_waitrequest,
  output logic [AVN_DW-1:0]        s_readdata,
  output logic [NREQ-1:0]          s_readdatavalid,
  output logic [AVN_AW-1:0]        m_address,
  output logic                     m_read,
  output logic                     m_write,
  output logic [AVN_DW-1:0]        m_writedata,
  input  logic                     m_waitrequest,
  input  logic [AVN_DW-1:0]        m_readdata,
  input  logic                     m_readdatavalid,
  output logic                     err
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int PW = $clog2(OUTSTD);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] lock_q, lock_d, gnt, arb, head;
  logic arb_vld, gnt_vld, accept, push, pop;
  logic [NREQ-1:0] elig;
  logic [IW-1:0] fifo_q [OUTSTD];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic err_q;
  // count is the registered value, so a same-cycle pop never unblocks a read
  always_comb begin
    for (int i = 0; i < NREQ; i++) elig[i] = s_write[i] | (s_read[i] & (cnt_q < CW'(OUTSTD)));
  end
`ifdef DLA_ARB_RR_EN
  logic [IW-1:0] last_q;
  logic [IW:0] idx;
  always_comb begin
    arb = '0;
    arb_vld = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, last_q} + (IW+1)'(k + 1);
      idx = idx >= (IW+1)'(NREQ) ? idx - (IW+1)'(NREQ) : idx;
      if (elig[idx[IW-1:0]]) begin
        arb = idx[IW-1:0];
        arb_vld = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= IW'(NREQ - 1);
    else if (accept) last_q <= gnt;
  end
`else
  always_comb begin
    arb = '0;
    arb_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        arb = IW'(i);
        arb_vld = 1'b1;
      end
    end
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q <= '0;
    end else begin
      state_q <= state_d;
      lock_q <= lock_d;
    end
  end
  always_comb begin
    state_d = state_q;
    lock_d = lock_q;
    if (state_q == IDLE) begin
      if (gnt_vld && m_waitrequest) begin
        state_d = LOCK;
        lock_d = arb;
      end
    end else if (!gnt_vld || !m_waitrequest) state_d = IDLE;
  end
  always_comb begin
    gnt = state_q == LOCK ? lock_q : arb;
    gnt_vld = ~rst & (state_q == LOCK ? elig[lock_q] : arb_vld);
    m_write = gnt_vld & s_write[gnt];
    m_read = gnt_vld & s_read[gnt] & ~s_write[gnt];
    m_address = gnt_vld ? s_address[gnt*AVN_AW +: AVN_AW] : '0;
    m_writedata = gnt_vld ? s_writedata[gnt*AVN_DW +: AVN_DW] : '0;
    accept = gnt_vld & ~m_waitrequest;
    push = accept & m_read;
    pop = m_readdatavalid & (cnt_q != '0);
    head = fifo_q[rd_q];
    for (int i = 0; i < NREQ; i++) begin
      s_waitrequest[i] = ~(gnt_vld & (gnt == IW'(i)) & ~m_waitrequest);
      s_readdatavalid[i] = pop & (head == IW'(i));
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= gnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      wr_q <= wr_q + PW'(push);
      rd_q <= rd_q + PW'(pop);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      err_q <= err_q | (m_readdatavalid & (cnt_q == '0));
    end
  end
  assign s_readdata = m_readdata;
  assign err = err_q;
endmodule

// File: tb/tb_dla_vram_arbiter.sv
// tb_dla_vram_arbiter: directed plus random stimulus checked against a queue-based reference model.
module tb_dla_vram_arbiter;
  localparam int NREQ = 3, AW = 19, DW = 16, OUTSTD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ*AW-1:0] s_address = '0;
  logic [NREQ-1:0] s_read = '0, s_write = '0;
  logic [NREQ*DW-1:0] s_writedata = '0;
  logic [NREQ-1:0] s_waitrequest, s_readdatavalid;
  logic [DW-1:0] s_readdata, m_writedata;
  logic [AW-1:0] m_address;
  logic m_read, m_write, err;
  logic m_waitrequest = 1'b0, m_readdatavalid = 1'b0;
  logic [DW-1:0] m_readdata = '0;

  dla_vram_arbiter #(.NREQ(NREQ), .AVN_AW(AW), .AVN_DW(DW), .OUTSTD(OUTSTD)) dut (
    .clk(clk), .rst(rst), .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .err(err));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int q[$];
  int due[$];
  bit locked = 0, err_m = 0, gv = 0, auto_rv = 1;
  int lock_id = 0, last = NREQ - 1, g = 0, cyc = 0, lat = 3, rd2 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit elig(int i);
    return s_write[i] || (s_read[i] && q.size() < OUTSTD);
  endfunction

  task automatic eval_check();
    logic [NREQ-1:0] wr, rv;
    if (rst) begin
      q.delete();
      locked = 0;
      last = NREQ - 1;
      err_m = 0;
    end
    gv = 0;
    g = 0;
    if (!rst) begin
      if (locked) begin
        g = lock_id;
        gv = elig(g);
      end else begin
`ifdef DLA_ARB_RR_EN
        for (int k = NREQ; k >= 1; k--) if (elig((last + k) % NREQ)) begin g = (last + k) % NREQ; gv = 1; end
`else
        for (int i = NREQ - 1; i >= 0; i--) if (elig(i)) begin g = i; gv = 1; end
`endif
      end
    end
    wr = '1;
    if (gv && !m_waitrequest) wr[g] = 1'b0;
    rv = '0;
    if (!rst && m_readdatavalid && q.size() > 0) rv[q[0]] = 1'b1;
    chk("m_write", 32'(m_write), 32'(gv && s_write[g]));
    chk("m_read", 32'(m_read), 32'(gv && s_read[g] && !s_write[g]));
    chk("m_address", 32'(m_address), gv ? 32'(s_address[g*AW +: AW]) : 32'd0);
    chk("m_writedata", 32'(m_writedata), gv ? 32'(s_writedata[g*DW +: DW]) : 32'd0);
    chk("s_waitrequest", 32'(s_waitrequest), 32'(wr));
    chk("s_readdatavalid", 32'(s_readdatavalid), 32'(rv));
    chk("s_readdata", 32'(s_readdata), 32'(m_readdata));
    chk("err", 32'(err), 32'(err_m));
  endtask

  task automatic update();
    int d;
    if (rst) return;
    if (m_readdatavalid) begin
      if (q.size() > 0) void'(q.pop_front());
      else err_m = 1;
    end
    if (gv && !m_waitrequest) begin
      if (s_read[g] && !s_write[g]) begin
        q.push_back(g);
        if (g == 2) rd2++;
        d = cyc + lat;
        if (due.size() > 0 && d <= due[$]) d = due[$] + 1;
        due.push_back(d);
      end
      last = g;
      locked = 0;
    end else if (gv) begin
      locked = 1;
      lock_id = g;
    end else locked = 0;
  endtask

  task automatic pre();
    if (auto_rv) begin
      m_readdatavalid = due.size() > 0 && due[0] <= cyc;
      if (m_readdatavalid) void'(due.pop_front());
    end
    m_readdata = DW'($urandom);
    #1;
    eval_check();
  endtask

  task automatic post();
    @(posedge clk);
    update();
    cyc++;
    #1;
  endtask

  task automatic step();
    pre();
    post();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    s_read = '0;
    s_write = '0;
    m_waitrequest = 1'b0;
    due.delete();
    step();
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset with every requester asking
    rst = 1'b1;
    s_write = '1;
    pre();
    chk("rst_wait", 32'(s_waitrequest), 32'h7);
    chk("rst_mwrite", 32'(m_write), 32'h0);
    post();
    rst = 1'b0;
    // single write from requester 0
    s_write = 3'b001;
    s_address[0 +: AW] = 19'h00100;
    s_writedata[0 +: DW] = 16'hFFFF;
    pre();
    chk("wr_addr", 32'(m_address), 32'h100);
    chk("wr_wait", 32'(s_waitrequest), 32'h6);
    post();
    // contention
    reset_dut();
    for (int i = 0; i < NREQ; i++) s_address[i*AW +: AW] = AW'(32'h10 + i);
    s_write = 3'b111;
    for (int k = 0; k < 6; k++) begin
      pre();
`ifdef DLA_ARB_RR_EN
      chk("contention", 32'(m_address), 32'h10 + 32'(k % 3));
`else
      chk("contention", 32'(m_address), 32'h10);
`endif
      post();
    end
    // lock across a stall
    reset_dut();
    s_address[0 +: AW] = 19'h111;
    s_address[AW +: AW] = 19'h222;
    s_write = 3'b010;
    m_waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k >= 1) s_write = 3'b011;
      pre();
      chk("lock_addr", 32'(m_address), 32'h222);
      post();
    end
    m_waitrequest = 1'b0;
    pre();
    chk("lock_accept", 32'(s_waitrequest), 32'h5);
    post();
    s_write = 3'b001;
    pre();
    chk("lock_next", 32'(m_address), 32'h111);
    post();
    // outstanding-read limit and in-order routing
    reset_dut();
    lat = 4;
    rd2 = 0;
    s_address[2*AW +: AW] = 19'h333;
    s_read = 3'b100;
    for (int k = 0; k < 20 && rd2 < 5; k++) begin
      pre();
      if (k == 4) chk("outstd_stall", 32'(s_waitrequest[2]), 32'h1);
      post();
    end
    chk("reads_issued", 32'(rd2), 32'd5);
    s_read = '0;
    for (int k = 0; k < 8; k++) step();
    lat = 3;
    for (int k = 0; k < 10; k++) begin
      s_read = (k % 2) ? 3'b100 : 3'b010;
      step();
    end
    s_read = '0;
    for (int k = 0; k < 8; k++) step();
    // spurious response
    reset_dut();
    auto_rv = 0;
    m_readdatavalid = 1'b1;
    pre();
    chk("spur_rv", 32'(s_readdatavalid), 32'h0);
    post();
    m_readdatavalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pre();
      chk("err_sticky", 32'(err), 32'h1);
      post();
    end
    rst = 1'b1;
    pre();
    chk("err_rst", 32'(err), 32'h0);
    post();
    rst = 1'b0;
    auto_rv = 1;
    // random traffic with occasional mid-transfer reset
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 299) == 0;
      for (int i = 0; i < NREQ; i++) begin
        s_read[i] = $urandom_range(0, 2) == 0;
        s_write[i] = $urandom_range(0, 3) == 0;
        if ($urandom_range(0, 3) == 0) s_address[i*AW +: AW] = AW'($urandom);
        if ($urandom_range(0, 3) == 0) s_writedata[i*DW +: DW] = DW'($urandom);
      end
      m_waitrequest = $urandom_range(0, 2) == 0;
      lat = $urandom_range(1, 5);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
